map_row_prefetcher: RTL and testbench
=====================================

Name: map_row_prefetcher

Overview:
- Sequences the world-map RAM port for the display path and shares it with the bot-sensor requester.
- Prefetches the next 128-cell map row into a ping-pong line buffer. Fetches run during horizontal blanking of the last pixel line of each cell row.
- During active video it drives map_value to map_colorizer with fixed 1-clk latency, plus aligned row/column.
- Sits between the world-map RAM and map_colorizer. clk is the pixel clock: one pixel per cycle.

Parameters:
- MAP_W, 128, cells per map row; power of 2.
- CELL_SHIFT, 3, log2 of cell size in pixels (8x8 cells).
- H_ACTIVE, 1024, visible columns.
- V_ACTIVE, 768, visible rows; must be a multiple of 2^CELL_SHIFT.

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- pixel_row  in  12  current display row
- pixel_column  in  12  current display column
- video_on  in  1  active-video flag
- map_addr  out  14  map RAM address {cell_row[6:0], cell_col[6:0]}
- map_rd_en  out  1  map RAM read strobe
- map_data  in  2  map RAM data, valid 1 clk after map_rd_en
- bot_req  in  1  bot read request, level, held until bot_gnt
- bot_addr  in  14  bot read address, stable while bot_req
- bot_gnt  out  1  1-clk grant pulse
- bot_data  out  2  bot read data
- bot_data_valid  out  1  1-clk pulse, 1 clk after bot_gnt
- map_value  out  2  cell value to colorizer
- out_row  out  12  pixel_row delayed 1 clk
- out_column  out  12  pixel_column delayed 1 clk
- out_video_on  out  1  video_on delayed 1 clk

Behaviour:
- Reset: asynchronous on resetn low. All outputs 0, FSM IDLE, pending flag 0, both line buffers 0. Release is synchronous.
- Cell indices:
  - cur_cell_row = pixel_row >> CELL_SHIFT.
  - next_cell_row = cur_cell_row+1, wrapping to 0 when it equals V_ACTIVE>>CELL_SHIFT (96 cell rows).
- Trigger: single-cycle when pixel_column==H_ACTIVE, pixel_row<V_ACTIVE and pixel_row[CELL_SHIFT-1:0] all ones. It sets the pending flag.
- Buffer selection: display reads buffer cur_cell_row[0]; fill writes buffer next_cell_row[0], latched at trigger.
- FSM states:
  - IDLE: pending -> FILL (clear pending). Otherwise, if bot_req -> BOT.
  - BOT: one cycle. map_addr=bot_addr, map_rd_en=1, bot_gnt=1. Next cycle: bot_data=map_data, bot_data_valid=1, return to IDLE. Pending set during BOT is served next.
  - FILL: cnt 0..MAP_W-1. map_addr={fill_row, cnt}, map_rd_en=1. Data returned 1 clk later is written to fill buffer[cnt-1]. After cnt==MAP_W-1 -> DRAIN.
  - DRAIN: write last cell (MAP_W-1), map_rd_en=0 -> IDLE.
- Fill occupies MAP_W+1 clks (129). This fits in the 320-clk blanking of 1024x768.
- Fill always beats bot. bot_gnt is never asserted during FILL or DRAIN. Worst-case bot wait is 130 clks.
- bot_req must stay asserted until bot_gnt; it may drop the cycle after. Requester re-arms by re-asserting.
- Trigger arriving during FILL: not possible at legal timing. If it occurs, pending is set and served after DRAIN.
- Display path, registered, 1-clk latency:
  - map_value = buffer[disp_sel][pixel_column>>CELL_SHIFT] when video_on and pixel_column<H_ACTIVE, else 0.
  - out_row, out_column and out_video_on track the same cycle.
- First frame after reset shows value 0 for cell row 0. Row 0 is fetched at the end of the last visible line (row 767).
- Reset mid-FILL aborts the fill; the buffer is cleared to 0.

Decomposition:
- Package map_pkg: MAP_W, CELL_SHIFT, H_ACTIVE, V_ACTIVE, MAP_ADDR_W=14, cell-value constants (GRASS=2'b00, ROAD=2'b01, OBSTACLE=2'b10), FSM state enum {IDLE, BOT, FILL, DRAIN}.
- One sub-module: map_line_buffer.
  - 2 x MAP_W x 2-bit ping-pong storage, async-reset to 0.
  - One synchronous write port (sel, idx, data, we) and one combinational read port (sel, idx).

Test Plan:
- Reset: hold resetn=0 for 5 clks mid-line -> all outputs 0, bot_gnt 0; after release map_value=0 throughout frame 0 row 0.
- Fill sequence: map RAM row 1 = cells col k value k%3. Drive row 7, column 1024 -> map_rd_en high 128 clks, map_addr 0x0080..0x00FF, then DRAIN. On row 8, column 8k+j, map_value = k%3 one clk later.
- Wrap: at row 767, column 1024 -> fetch map_addr 0x0000..0x007F into buffer 0. Next frame row 0 shows map row 0 data.
- Bot in idle: bot_req=1, bot_addr=0x1234 (RAM=2'b10) during active video -> bot_gnt next clk with map_addr=0x1234; bot_data=2'b10, bot_data_valid one clk later.
- Collision: bot_req asserted same clk as trigger -> FILL wins; bot_gnt exactly 1 clk after DRAIN completes (130 clks later), correct data returned.
- Latency/blanking: video_on=0 or column>=1024 -> map_value=0. out_row/out_column equal inputs delayed exactly 1 clk.

Source files
------------

// File: rtl/map_pkg.sv
//------------------------------------------------------------------------------
// Module   : map_pkg
// Purpose  : Shared geometry, cell-value constants and FSM encoding for the
//            map row prefetcher.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package map_pkg;

    localparam int MAP_W      = 128;
    localparam int CELL_SHIFT = 3;
    localparam int H_ACTIVE   = 1024;
    localparam int V_ACTIVE   = 768;
    localparam int MAP_ADDR_W = 14;
    localparam int PIX_W      = 12;
    localparam int COL_W      = $clog2(MAP_W);
    localparam int ROW_W      = MAP_ADDR_W - COL_W;
    localparam int CELL_ROWS  = V_ACTIVE >> CELL_SHIFT;

    localparam logic [1:0] GRASS    = 2'b00;
    localparam logic [1:0] ROAD     = 2'b01;
    localparam logic [1:0] OBSTACLE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BOT   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/map_row_prefetcher_if.sv
//------------------------------------------------------------------------------
// Module   : map_row_prefetcher_if
// Purpose  : Map RAM read port plus bot-sensor request channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface map_row_prefetcher_if;
    import map_pkg::*;

    logic [MAP_ADDR_W-1:0] map_addr;
    logic                  map_rd_en;
    logic [1:0]            map_data;
    logic                  bot_req;
    logic [MAP_ADDR_W-1:0] bot_addr;
    logic                  bot_gnt;
    logic [1:0]            bot_data;
    logic                  bot_data_valid;

    modport master (
        output map_addr, map_rd_en, bot_gnt, bot_data, bot_data_valid,
        input  map_data, bot_req, bot_addr
    );

    modport slave (
        input  map_addr, map_rd_en, bot_gnt, bot_data, bot_data_valid,
        output map_data, bot_req, bot_addr
    );

endinterface

`default_nettype wire

// File: rtl/map_line_buffer.sv
//------------------------------------------------------------------------------
// Module   : map_line_buffer
// Purpose  : Two-bank ping-pong cell row storage, sync write, comb read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module map_line_buffer
    import map_pkg::*;
#(
    parameter  int DEPTH = MAP_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             wr_sel,
    input  wire logic [IDX_W-1:0] wr_idx,
    input  wire logic [1:0]       wr_data,
    input  wire logic             wr_en,
    input  wire logic             rd_sel,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [1:0]       rd_data
);

    logic [1:0] mem_q [2][DEPTH];
    logic [1:0] mem_d [2][DEPTH];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar i = 0; i < DEPTH; i++) begin : g_cell
            always_comb begin
                mem_d[b][i] = mem_q[b][i];
                if (wr_en && (wr_sel == 1'(b)) && (wr_idx == IDX_W'(i))) begin
                    mem_d[b][i] = wr_data;
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    mem_q[b][i] <= '0;
                end else begin
                    mem_q[b][i] <= mem_d[b][i];
                end
            end
        end
    end

    assign rd_data = mem_q[rd_sel][rd_idx];

endmodule

`default_nettype wire

// File: rtl/map_row_prefetcher.sv
//------------------------------------------------------------------------------
// Module   : map_row_prefetcher
// Purpose  : Prefetches the next map row in blanking, serves bot reads, and
//            feeds cell values to the colorizer with 1-clk latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module map_row_prefetcher
    import map_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic [PIX_W-1:0] pixel_row,
    input  wire logic [PIX_W-1:0] pixel_column,
    input  wire logic             video_on,
    map_row_prefetcher_if.master  bus,
    output logic      [1:0]       map_value,
    output logic      [PIX_W-1:0] out_row,
    output logic      [PIX_W-1:0] out_column,
    output logic                  out_video_on
);

    localparam int CR_W = PIX_W - CELL_SHIFT;

    state_e           state_q, state_d;
    logic [COL_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] fill_row_q, fill_row_d;
    logic             pending_q, pending_d;
    logic [ROW_W-1:0] pending_row_q, pending_row_d;
    logic             wr_pend_q, wr_pend_d;
    logic [COL_W-1:0] wr_idx_q, wr_idx_d;
    logic             bot_rd_q, bot_rd_d;
    logic [1:0]       map_value_q, map_value_d;
    logic [PIX_W-1:0] out_row_q, out_column_q;
    logic             out_video_on_q;

    logic [CR_W-1:0]  cur_cell_row;
    logic [ROW_W-1:0] next_cell_row;
    logic             trigger;
    logic             pend_any;
    logic [ROW_W-1:0] pend_row;
    logic [1:0]       disp_data;

    assign cur_cell_row  = pixel_row[PIX_W-1:CELL_SHIFT];
    assign next_cell_row = (cur_cell_row == CR_W'(CELL_ROWS - 1)) ? '0
                         : cur_cell_row[ROW_W-1:0] + 1'b1;
    assign trigger = (pixel_column == PIX_W'(H_ACTIVE))
                  && (pixel_row < PIX_W'(V_ACTIVE))
                  && (&pixel_row[CELL_SHIFT-1:0]);

    // A trigger in the same cycle counts as pending so fill beats a bot request.
    assign pend_any = pending_q | trigger;
    assign pend_row = trigger ? next_cell_row : pending_row_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fill_row_q     <= '0;
            pending_q      <= 1'b0;
            pending_row_q  <= '0;
            wr_pend_q      <= 1'b0;
            wr_idx_q       <= '0;
            bot_rd_q       <= 1'b0;
            map_value_q    <= '0;
            out_row_q      <= '0;
            out_column_q   <= '0;
            out_video_on_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fill_row_q     <= fill_row_d;
            pending_q      <= pending_d;
            pending_row_q  <= pending_row_d;
            wr_pend_q      <= wr_pend_d;
            wr_idx_q       <= wr_idx_d;
            bot_rd_q       <= bot_rd_d;
            map_value_q    <= map_value_d;
            out_row_q      <= pixel_row;
            out_column_q   <= pixel_column;
            out_video_on_q <= video_on;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fill_row_d    = fill_row_q;
        pending_d     = pending_q;
        pending_row_d = pending_row_q;
        if (trigger) begin
            pending_d     = 1'b1;
            pending_row_d = next_cell_row;
        end
        case (state_q)
            // DRAIN arbitrates like IDLE so a waiting bot is granted right after it.
            IDLE, DRAIN: begin
                if (pend_any) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    fill_row_d = pend_row;
                    pending_d  = 1'b0;
                end else if (bus.bot_req) begin
                    state_d = BOT;
                end else begin
                    state_d = IDLE;
                end
            end
            BOT: state_d = IDLE;
            FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == COL_W'(MAP_W - 1)) begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.map_addr       = '0;
        bus.map_rd_en      = 1'b0;
        bus.bot_gnt        = 1'b0;
        bus.bot_data_valid = bot_rd_q;
        bus.bot_data       = bot_rd_q ? bus.map_data : 2'b00;
        wr_pend_d          = (state_q == FILL);
        wr_idx_d           = cnt_q;
        bot_rd_d           = (state_q == BOT);
        case (state_q)
            BOT: begin
                bus.map_addr  = bus.bot_addr;
                bus.map_rd_en = 1'b1;
                bus.bot_gnt   = 1'b1;
            end
            FILL: begin
                bus.map_addr  = {fill_row_q, cnt_q};
                bus.map_rd_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        map_value_d = 2'b00;
        if (video_on && (pixel_column < PIX_W'(H_ACTIVE))) begin
            map_value_d = disp_data;
        end
    end

    map_line_buffer #(.DEPTH(MAP_W)) u_line_buffer (
        .clk     (clk),
        .resetn  (resetn),
        .wr_sel  (fill_row_q[0]),
        .wr_idx  (wr_idx_q),
        .wr_data (bus.map_data),
        .wr_en   (wr_pend_q),
        .rd_sel  (cur_cell_row[0]),
        .rd_idx  (pixel_column[CELL_SHIFT +: COL_W]),
        .rd_data (disp_data)
    );

    assign map_value    = map_value_q;
    assign out_row      = out_row_q;
    assign out_column   = out_column_q;
    assign out_video_on = out_video_on_q;

endmodule

`default_nettype wire

// File: tb/tb_map_row_prefetcher.sv
//------------------------------------------------------------------------------
// Module   : tb_map_row_prefetcher
// Purpose  : Self-checking bench against a cell-level model of the map display.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_map_row_prefetcher;
    import map_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        video_on;
    logic [1:0]  map_value;
    logic [11:0] out_row;
    logic [11:0] out_column;
    logic        out_video_on;

    map_row_prefetcher_if bus();

    map_row_prefetcher dut (
        .clk          (clk),
        .resetn       (resetn),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .video_on     (video_on),
        .bus          (bus),
        .map_value    (map_value),
        .out_row      (out_row),
        .out_column   (out_column),
        .out_video_on (out_video_on)
    );

    always #5 clk = ~clk;

    logic [1:0] ram [0:16383];
    logic [1:0] exp_buf [2][128];
    int vectors = 0;
    int miscompares = 0;

    // Map RAM model: one-clock read latency.
    always @(posedge clk) bus.map_data <= bus.map_rd_en ? ram[bus.map_addr] : 2'b00;

    task automatic step(input int r, input int c, input logic v);
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        video_on     = v;
        @(posedge clk);
        #1;
    endtask

    function automatic int next_row_of(input int r);
        return ((r / 8) + 1) % 96;
    endfunction

    task automatic model_fill(input int r);
        int nr = next_row_of(r);
        for (int k = 0; k < 128; k++) exp_buf[nr % 2][k] = ram[nr * 128 + k];
    endtask

    task automatic run_fill(input int r);
        int base = next_row_of(r) * 128;
        step(r, 1024, 1'b0);
        for (int i = 0; i < 128; i++) begin
            vectors++;
            if (bus.map_rd_en !== 1'b1 || bus.map_addr !== 14'(base + i) || bus.bot_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_addr i=%0d: got rd_en=%b addr=%h gnt=%b, want rd_en=1 addr=%h gnt=0",
                         i, bus.map_rd_en, bus.map_addr, bus.bot_gnt, 14'(base + i));
            end
            step(r, 1025 + i, 1'b0);
        end
        vectors++;
        if (bus.map_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_rd_en: got %b want 0", bus.map_rd_en);
        end
        model_fill(r);
        step(r, 1200, 1'b0);
    endtask

    task automatic check_display_row(input int r);
        logic [1:0] exp;
        for (int c = 0; c < 1024; c++) begin
            step(r, c, 1'b1);
            exp = exp_buf[(r / 8) % 2][c / 8];
            vectors++;
            if (map_value !== exp || out_row !== 12'(r) || out_column !== 12'(c) || out_video_on !== 1'b1) begin
                miscompares++;
                $display("FAIL display r=%0d c=%0d: got val=%b row=%0d col=%0d von=%b, want val=%b row=%0d col=%0d von=1",
                         r, c, map_value, out_row, out_column, out_video_on, exp, r, c);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.bot_req  = 1'b1;
        bus.bot_addr = 14'h0123;
        for (int i = 0; i < 5; i++) begin
            step(300, 400 + i, 1'b1);
            vectors++;
            if (map_value !== 2'b00 || out_row !== 12'd0 || out_column !== 12'd0 || out_video_on !== 1'b0 ||
                bus.bot_gnt !== 1'b0 || bus.map_rd_en !== 1'b0 || bus.map_addr !== 14'd0 ||
                bus.bot_data_valid !== 1'b0 || bus.bot_data !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d: got val=%b row=%0d col=%0d von=%b gnt=%b rd=%b addr=%h bv=%b bd=%b, want all 0",
                         i, map_value, out_row, out_column, out_video_on, bus.bot_gnt, bus.map_rd_en,
                         bus.map_addr, bus.bot_data_valid, bus.bot_data);
            end
        end
        bus.bot_req = 1'b0;
        resetn = 1'b1;
        check_display_row(0);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 128; k++) ram[128 + k] = 2'(k % 3);
        run_fill(7);
        check_display_row(8);
    endtask

    task automatic test_wrap();
        run_fill(767);
        check_display_row(0);
    endtask

    task automatic test_bot_idle();
        logic [13:0] a;
        logic [1:0]  exp;
        ram[14'h1234] = 2'b10;
        for (int n = 0; n < 8; n++) begin
            a   = (n == 0) ? 14'h1234 : 14'($urandom);
            exp = ram[a];
            bus.bot_req  = 1'b1;
            bus.bot_addr = a;
            step(8, $urandom_range(0, 1023), 1'b1);
            vectors++;
            if (bus.bot_gnt !== 1'b1 || bus.map_rd_en !== 1'b1 || bus.map_addr !== a) begin
                miscompares++;
                $display("FAIL bot_grant n=%0d: got gnt=%b rd=%b addr=%h, want gnt=1 rd=1 addr=%h",
                         n, bus.bot_gnt, bus.map_rd_en, bus.map_addr, a);
            end
            bus.bot_req = 1'b0;
            step(8, $urandom_range(0, 1023), 1'b1);
            vectors++;
            if (bus.bot_data_valid !== 1'b1 || bus.bot_data !== exp || bus.bot_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL bot_data n=%0d: got valid=%b data=%b gnt=%b, want valid=1 data=%b gnt=0",
                         n, bus.bot_data_valid, bus.bot_data, bus.bot_gnt, exp);
            end
            step(8, $urandom_range(0, 1023), 1'b1);
            vectors++;
            if (bus.bot_data_valid !== 1'b0 || bus.bot_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL bot_idle_after n=%0d: got valid=%b gnt=%b, want 0 0",
                         n, bus.bot_data_valid, bus.bot_gnt);
            end
        end
    endtask

    task automatic test_collision();
        logic [13:0] a = 14'($urandom);
        logic [1:0]  exp = ram[a];
        int waited;
        bus.bot_req  = 1'b1;
        bus.bot_addr = a;
        step(15, 1024, 1'b0);
        waited = 1;
        while (bus.bot_gnt !== 1'b1 && waited < 200) begin
            step(15, 1025 + waited, 1'b0);
            waited++;
        end
        vectors++;
        if (waited != 130 || bus.map_addr !== a) begin
            miscompares++;
            $display("FAIL collision_wait: got gnt after %0d clks addr=%h, want 130 clks addr=%h",
                     waited, bus.map_addr, a);
        end
        bus.bot_req = 1'b0;
        step(15, 1400, 1'b0);
        vectors++;
        if (bus.bot_data_valid !== 1'b1 || bus.bot_data !== exp) begin
            miscompares++;
            $display("FAIL collision_data: got valid=%b data=%b, want valid=1 data=%b",
                     bus.bot_data_valid, bus.bot_data, exp);
        end
        model_fill(15);
        check_display_row(16);
    endtask

    task automatic test_blanking();
        int r, c;
        logic v;
        logic [1:0] exp;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 767);
            c = $urandom_range(0, 2047);
            if (c == 1024) c = 1025;
            v = 1'($urandom);
            step(r, c, v);
            exp = (v && c < 1024) ? exp_buf[(r / 8) % 2][c / 8] : 2'b00;
            vectors++;
            if (map_value !== exp || out_row !== 12'(r) || out_column !== 12'(c) || out_video_on !== v) begin
                miscompares++;
                $display("FAIL blanking r=%0d c=%0d v=%b: got val=%b row=%0d col=%0d von=%b, want val=%b",
                         r, c, v, map_value, out_row, out_column, out_video_on, exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn       = 1'b0;
        pixel_row    = '0;
        pixel_column = '0;
        video_on     = 1'b0;
        bus.bot_req  = 1'b0;
        bus.bot_addr = '0;
        for (int i = 0; i < 16384; i++) ram[i] = 2'($urandom_range(0, 2));
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 128; k++) exp_buf[b][k] = 2'b00;

        test_reset();
        test_fill();
        test_wrap();
        test_bot_idle();
        test_collision();
        test_blanking();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
